// File: rtl/aes_round_engine.sv
// aes_round_engine
// Iterative AES-128 encryption core that completes one cipher round per clock.
// Round keys come straight from an external key expander. The core does not
// latch them, so they must stay stable from the start edge until the final
// round edge.
//
// Ports
//   clk        : single clock; all state changes on the rising edge
//   reset      : synchronous, active-high; forces IDLE and clears all outputs
//   start      : encrypt request; sampled only in IDLE
//   plaintext  : 128-bit input block; byte s0,0 sits in [127:120], column-major
//   aes_key    : round-0 key (the cipher key)
//   key1..key10: round keys 1 through 10, in the same byte order
//   ciphertext : registered result; held until the next block completes
//   busy       : high while a block is in flight
//   done       : one-cycle pulse when ciphertext has just been updated
//
// Timing: start is sampled at edge E0, rounds 1-10 run on E1-E10, and done is
// high for the cycle after E10. The next start is accepted one cycle later,
// which gives one block every 12 cycles.

module aes_round_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] aes_key,
  input  logic [127:0] key1,
  input  logic [127:0] key2,
  input  logic [127:0] key3,
  input  logic [127:0] key4,
  input  logic [127:0] key5,
  input  logic [127:0] key6,
  input  logic [127:0] key7,
  input  logic [127:0] key8,
  input  logic [127:0] key9,
  input  logic [127:0] key10,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic         done
);

  // Forward S-box. Element 0 is the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic [127:0] state_q;

  logic [127:0] sb_out;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic [127:0] round_key;

  // Byte k of the block occupies bits [127-8k -: 8]; byte k = row + 4*column.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = SBOX[s[127-8*k -: 8]];
    end
    return o;
  endfunction

  // Row r rotates left by r positions, so output column c takes input column c+r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    {a0, a1, a2, a3} = c;
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign sb_out = sub_bytes(state_q);
  assign sr_out = shift_rows(sb_out);
  assign mc_out = mix_columns(sr_out);

  // Key for the intermediate rounds. The final round uses key10 directly.
  always_comb begin
    round_key = '0;
    case (rnd)
      4'd1:    round_key = key1;
      4'd2:    round_key = key2;
      4'd3:    round_key = key3;
      4'd4:    round_key = key4;
      4'd5:    round_key = key5;
      4'd6:    round_key = key6;
      4'd7:    round_key = key7;
      4'd8:    round_key = key8;
      4'd9:    round_key = key9;
      default: round_key = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= IDLE;
      rnd        <= 4'd0;
      state_q    <= '0;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q <= plaintext ^ aes_key;
            rnd     <= 4'd1;
            busy    <= 1'b1;
            fsm     <= ROUND;
          end else begin
            busy <= 1'b0;
          end
        end
        ROUND: begin
          if (rnd >= 4'd1 && rnd <= 4'd9) begin
            state_q <= mc_out ^ round_key;
            rnd     <= rnd + 4'd1;
          end else if (rnd == 4'd10) begin
            ciphertext <= sr_out ^ key10;
            done       <= 1'b1;
            busy       <= 1'b0;
            rnd        <= 4'd0;
            fsm        <= DONE;
          end else begin
            // Counter value outside 1..10: abandon the block quietly.
            busy <= 1'b0;
            done <= 1'b0;
            rnd  <= 4'd0;
            fsm  <= IDLE;
          end
        end
        DONE: begin
          done <= 1'b0;
          fsm  <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          rnd  <= 4'd0;
          fsm  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Testbench for aes_round_engine. It expands the cipher key into round keys
// itself and checks results against published AES-128 vectors.
module tb_aes_round_engine;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] CT1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K3  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P3  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT3 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] rk [0:10];
  logic [127:0] ciphertext;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q [$];
  logic [127:0] last_ct;
  bit           have_last = 0;

  always #5 clk = ~clk;

  aes_round_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .plaintext  (plaintext),
    .aes_key    (rk[0]),
    .key1       (rk[1]),
    .key2       (rk[2]),
    .key3       (rk[3]),
    .key4       (rk[4]),
    .key5       (rk[5]),
    .key6       (rk[6]),
    .key7       (rk[7]),
    .key8       (rk[8]),
    .key9       (rk[9]),
    .key10      (rk[10]),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {SBOX[w3[23:16]] ^ rcon, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic set_key(input logic [127:0] k);
    logic [7:0] rc;
    rc = 8'h01;
    rk[0] = k;
    for (int i = 1; i <= 10; i++) begin
      rk[i] = next_key(rk[i-1], rc);
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expected ciphertext.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got ciphertext %h expected no done pulse", ciphertext);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (ciphertext !== e) begin
          n_err++;
          $display("FAIL ciphertext: got %h expected %h", ciphertext, e);
        end
      end
    end
  end

  // Starts at a negedge; returns at the negedge where done is seen.
  task automatic wait_done(output int nbusy, output int ncyc);
    nbusy = 0;
    ncyc  = 0;
    while (done !== 1'b1 && ncyc < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      ncyc++;
    end
    if (done !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", ncyc);
    end
  endtask

  task automatic run_block(input string name, input logic [127:0] k, input logic [127:0] pt,
                           input logic [127:0] exp, input bit scramble);
    int nb, nc;
    @(negedge clk);
    set_key(k);
    plaintext = pt;
    start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    if (scramble) plaintext = ~pt;
    if (have_last) chk({name, "_ct_hold"}, ciphertext, last_ct);
    wait_done(nb, nc);
    chk_int({name, "_busy_cycles"}, nb, 10);
    chk_int({name, "_latency"}, nc, 10);
    @(negedge clk);
    chk_int({name, "_done_width"}, int'(done), 0);
    chk({name, "_ct_after"}, ciphertext, exp);
    last_ct = exp;
    have_last = 1;
  endtask

  initial begin
    int nb, nc;
    reset = 1'b1;
    start = 1'b0;
    plaintext = '0;
    set_key('0);
    repeat (3) @(negedge clk);
    chk("rst_ct", ciphertext, '0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
    reset = 1'b0;

    run_block("v_zero", '0, '0, CT1, 1'b0);
    run_block("v_fips", K2, P2, CT2, 1'b1);
    run_block("v_appb", K3, P3, CT3, 1'b1);

    // start held high: the second block is taken only after DONE.
    @(negedge clk);
    set_key(K2);
    plaintext = P2;
    start = 1'b1;
    exp_q.push_back(CT2);
    @(negedge clk);
    plaintext = P3;
    wait_done(nb, nc);
    chk_int("cont_a_latency", nc, 10);
    set_key('0);
    plaintext = '0;
    exp_q.push_back(CT1);
    @(negedge clk);
    chk_int("cont_start_in_done", int'(busy), 0);
    @(negedge clk);
    chk_int("cont_b_accept", int'(busy), 1);
    start = 1'b0;
    plaintext = P3;
    wait_done(nb, nc);
    chk_int("cont_b_latency", nc, 10);
    @(negedge clk);

    // Reset at round 5 aborts the block; the next block starts right away.
    @(negedge clk);
    set_key(K3);
    plaintext = P3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_int("abort_busy", int'(busy), 0);
    chk_int("abort_done", int'(done), 0);
    chk("abort_ct", ciphertext, '0);
    reset = 1'b0;
    set_key(K2);
    plaintext = P2;
    start = 1'b1;
    exp_q.push_back(CT2);
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, nc);
    chk_int("post_abort_latency", nc, 10);
    @(negedge clk);

    // reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    plaintext = P3;
    @(negedge clk);
    chk_int("rst_start_busy", int'(busy), 0);
    @(negedge clk);
    chk_int("rst_start_busy2", int'(busy), 0);
    chk("rst_start_ct", ciphertext, '0);
    reset = 1'b0;
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk_int("rst_start_no_done", int'(done), 0);
    chk_int("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_round_engine.md
AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
- REQ-001: Parameters: none.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- REQ-004: start  input  1  request to encrypt plaintext; sampled only in IDLE.
- REQ-005: plaintext  input  128  input block; bits [127:120] = byte s0,0, column-major per FIPS-197.
- REQ-006: aes_key  input  128  cipher key, used as round-0 key.
- REQ-007: key1 .. key10  input  128 each  round keys 1-10 from key_expand, same byte order.
- REQ-008: ciphertext  output  128  registered result block.
- REQ-009: busy  output  1  high while a block is being processed.
- REQ-010: done  output  1  one-cycle pulse marking ciphertext valid.

Function
- REQ-011: Block shall perform iterative AES-128 encryption, one round per clock, consuming key_expand outputs directly.
- REQ-012: FSM states: IDLE, ROUND, DONE.
- REQ-013: IDLE with start=1 at edge E0: state register <= plaintext XOR aes_key; round counter <= 1; busy <= 1; go to ROUND.
- REQ-014: IDLE with start=0: hold state; busy=0.
- REQ-015: ROUND, counter r in 1..9: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key_r); counter <= r+1.
- REQ-016: ROUND, counter r=10: ciphertext <= AddRoundKey(ShiftRows(SubBytes(state)), key10), no MixColumns; done <= 1; busy <= 0; go to DONE.
- REQ-017: DONE: done <= 0; go to IDLE next edge; start in DONE shall be ignored.
- REQ-018: Latency: start sampled at E0; ciphertext and done valid after edge E10; done high exactly one cycle.
- REQ-019: Throughput: one block per 12 cycles; next start accepted at earliest in cycle after DONE.
- REQ-020: start while busy=1 shall be ignored; plaintext and keys not re-sampled.
- REQ-021: plaintext sampled only at E0; later changes shall not affect result.
- REQ-022: aes_key and key1..key10 shall be held stable by the user from E0 through E10; the block does not latch keys.
- REQ-023: SubBytes shall use the FIPS-197 forward S-box (16 parallel byte lookups, e.g. 00->63, 53->ed).
- REQ-024: MixColumns shall use GF(2^8) multiplication with reduction polynomial 0x11b; xtime = (b<<1) XOR (0x1b if b[7]).
- REQ-025: ShiftRows: row i rotated left by i bytes, row 0 unchanged.
- REQ-026: Round counter 4 bits; values 0, 11-15 unreachable; if reached, FSM shall return to IDLE with busy=0.
- REQ-027: ciphertext shall hold last result until next completion; not cleared by start.

Reset
- REQ-028: reset=1 at any edge shall force state IDLE, counter 0, state register 0, ciphertext 0, busy 0, done 0.
- REQ-029: reset mid-operation shall abort the block with no done pulse; reset has priority over start.
- REQ-030: After reset deassert, start accepted on first edge with reset=0.

Verification (bench instantiates key_expand feeding aes_round_engine)
- REQ-031: aes_key=0, plaintext=0, start 1 cycle -> done pulse 10 edges later; ciphertext=66e94bd4ef8a2c3b884cfa59ca342b2e.
- REQ-032: aes_key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff -> ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
- REQ-033: aes_key=2b7e151628aed2a6abf7158809cf4f3c, plaintext=3243f6a8885a308d313198a2e0370734 -> ciphertext=3925841d02dc09fbdc118597196a0b32; busy high exactly 10 cycles.
- REQ-034: start held high continuously with alternating plaintexts -> new block accepted only after DONE; each result matches its sampled plaintext; plaintext changed mid-block has no effect.
- REQ-035: reset asserted at round 5 -> next cycle busy=0, done=0, ciphertext=0; no done pulse follows; subsequent block from REQ-032 correct.
- REQ-036: start and reset both high -> reset wins; block stays IDLE, busy=0.
